// File: rtl/axi_lite_timer_regs.sv
// AXI4-Lite timer peripheral: free-running 32-bit counter with a compare
// register, a sticky match flag (write-1-to-clear) and a registered level
// interrupt. Write and read channels are independent three-state FSMs.
module axi_lite_timer_regs #(
  parameter int          ADDR_W  = 6,
  parameter logic [31:0] CNT_RST = 32'h0
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              irq
);

  localparam int         IW          = ADDR_W - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_ACCEPT = 2'd1,
    WR_RESP   = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_ACCEPT = 2'd1,
    RD_RESP   = 2'd2
  } rd_state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic reg_exists(input logic [IW-1:0] idx);
    return idx < IW'(4);
  endfunction

  wr_state_t   wr_state, wr_next;
  rd_state_t   rd_state, rd_next;
  logic [IW-1:0] wr_idx, rd_idx;
  logic        wr_fire, rd_fire;
  logic [2:0]  ctrl_q;
  logic        status_match_q;
  logic [31:0] compare_q;
  logic [31:0] count_q;
  logic        irq_p1;
  logic        match_hit;
  logic        status_clr;
  logic [31:0] ctrl_merged;
  logic [31:0] rd_word;
  logic [1:0]  rd_word_resp;
  logic        unused_bits;

  assign wr_idx      = s_axi_awaddr[ADDR_W-1:2];
  assign rd_idx      = s_axi_araddr[ADDR_W-1:2];
  // AW and W are sampled together in the single cycle the write FSM spends in ACCEPT
  assign wr_fire     = (wr_state == WR_ACCEPT);
  assign rd_fire     = (rd_state == RD_ACCEPT);
  assign match_hit   = ctrl_q[0] && (count_q == compare_q);
  assign status_clr  = wr_fire && (wr_idx == IW'(1)) && s_axi_wstrb[0] && s_axi_wdata[0];
  assign ctrl_merged = merge_bytes({29'd0, ctrl_q}, s_axi_wdata, s_axi_wstrb);
  assign irq         = irq_p1;
  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], ctrl_merged[31:3]};

  // Write FSM state register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) wr_state <= WR_IDLE;
    else                wr_state <= wr_next;
  end

  // Write FSM next state and handshake outputs
  always_comb begin
    wr_next       = wr_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (s_axi_awvalid && s_axi_wvalid) wr_next = WR_ACCEPT;
      end
      WR_ACCEPT: begin
        s_axi_awready = 1'b1;
        s_axi_wready  = 1'b1;
        wr_next       = WR_RESP;
      end
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  // Write response code captured at the handshake
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)  s_axi_bresp <= RESP_OKAY;
    else if (wr_fire)    s_axi_bresp <= reg_exists(wr_idx) ? RESP_OKAY : RESP_SLVERR;
  end

  // Read FSM state register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) rd_state <= RD_IDLE;
    else                rd_state <= rd_next;
  end

  // Read FSM next state and handshake outputs
  always_comb begin
    rd_next       = rd_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (s_axi_arvalid) rd_next = RD_ACCEPT;
      end
      RD_ACCEPT: begin
        s_axi_arready = 1'b1;
        rd_next       = RD_RESP;
      end
      RD_RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  // Read data mux over the register map
  always_comb begin
    rd_word      = 32'd0;
    rd_word_resp = RESP_OKAY;
    case (rd_idx)
      IW'(0):  rd_word = {29'd0, ctrl_q};
      IW'(1):  rd_word = {31'd0, status_match_q};
      IW'(2):  rd_word = compare_q;
      IW'(3):  rd_word = count_q;
      default: rd_word_resp = RESP_SLVERR;
    endcase
  end

  // Read data is frozen at the handshake and held until rready
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axi_rdata <= 32'd0;
      s_axi_rresp <= RESP_OKAY;
    end else if (rd_fire) begin
      s_axi_rdata <= rd_word;
      s_axi_rresp <= rd_word_resp;
    end
  end

  // CTRL and COMPARE byte-strobed writes
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      ctrl_q    <= 3'd0;
      compare_q <= 32'd0;
    end else if (wr_fire) begin
      if (wr_idx == IW'(0)) ctrl_q    <= ctrl_merged[2:0];
      if (wr_idx == IW'(2)) compare_q <= merge_bytes(compare_q, s_axi_wdata, s_axi_wstrb);
    end
  end

  // Sticky match flag; a match in the same cycle as a W1C keeps the flag set
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)  status_match_q <= 1'b0;
    else if (match_hit)  status_match_q <= 1'b1;
    else if (status_clr) status_match_q <= 1'b0;
  end

  // Counter step uses the CTRL value in effect before any same-cycle write
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      count_q <= CNT_RST;
    end else if (ctrl_q[0]) begin
      if (match_hit && ctrl_q[2]) count_q <= CNT_RST;
      else                        count_q <= count_q + 32'd1;
    end
  end

  // Registered interrupt level, one cycle behind STATUS/CTRL
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) irq_p1 <= 1'b0;
    else                irq_p1 <= status_match_q & ctrl_q[1];
  end

endmodule

// File: tb/tb_axi_lite_timer_regs.sv
// Bench for axi_lite_timer_regs: register-map vector table, hand-written
// timing sequences, and a randomized phase against a cycle-level model.
module tb_axi_lite_timer_regs;

  localparam int          ADDR_W  = 6;
  localparam logic [31:0] CNT_RST = 32'h0;
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  SLVERR  = 2'b10;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid, awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid, wready;
  logic [1:0]        bresp;
  logic              bvalid, bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid, arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid, rready;
  logic              irq;

  int n_tests = 0;
  int n_fail  = 0;

  axi_lite_timer_regs #(.ADDR_W(ADDR_W), .CNT_RST(CNT_RST)) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .s_axi_awaddr (awaddr),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_bresp  (bresp),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_araddr (araddr),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [2:0]  m_ctrl;
  logic        m_status;
  logic [31:0] m_compare;
  logic [31:0] m_count;
  logic        m_irq;
  logic        m_hit;
  logic        m_wr_go = 1'b0;
  logic [5:0]  m_wr_addr = '0;
  logic [31:0] m_wr_data = '0;
  logic [3:0]  m_wr_strb = '0;

  function automatic logic [31:0] m_merge(input logic [31:0] cur, input logic [31:0] d,
                                          input logic [3:0] s);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  assign m_hit = m_ctrl[0] && (m_count == m_compare);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctrl    <= 3'd0;
      m_status  <= 1'b0;
      m_compare <= 32'd0;
      m_count   <= CNT_RST;
      m_irq     <= 1'b0;
    end else begin
      if (m_ctrl[0]) m_count <= (m_hit && m_ctrl[2]) ? CNT_RST : m_count + 32'd1;
      m_irq <= m_status & m_ctrl[1];
      if (m_hit) m_status <= 1'b1;
      else if (m_wr_go && m_wr_addr == 6'h04 && m_wr_strb[0] && m_wr_data[0]) m_status <= 1'b0;
      if (m_wr_go && m_wr_addr == 6'h00 && m_wr_strb[0]) m_ctrl <= m_wr_data[2:0];
      if (m_wr_go && m_wr_addr == 6'h08) m_compare <= m_merge(m_compare, m_wr_data, m_wr_strb);
    end
  end

  function automatic void m_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    r = OKAY;
    d = 32'd0;
    case (a >> 2)
      6'd0:    d = {29'd0, m_ctrl};
      6'd1:    d = {31'd0, m_status};
      6'd2:    d = m_compare;
      6'd3:    d = m_count;
      default: r = SLVERR;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: handshake did not complete within cycle budget", name);
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit ok;
    ok   = 1'b0;
    resp = 2'b11;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      timeout_fail("wr_accept");
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    m_wr_addr = a; m_wr_data = d; m_wr_strb = s; m_wr_go = 1'b1;
    @(negedge clk);
    m_wr_go = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bvalid) begin ok = 1'b1; resp = bresp; break; end
      @(negedge clk);
    end
    if (!ok) timeout_fail("wr_bvalid");
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r,
                          output logic [31:0] md, output logic [1:0] mr);
    bit ok;
    ok = 1'b0; d = 32'd0; r = 2'b11; md = 32'd0; mr = 2'b00;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      timeout_fail("rd_accept");
      arvalid = 1'b0;
      return;
    end
    m_read(a, md, mr);
    @(negedge clk);
    arvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rvalid) begin ok = 1'b1; d = rdata; r = rresp; break; end
      @(negedge clk);
    end
    if (!ok) timeout_fail("rd_rvalid");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input bit wr, input logic [5:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] er, input logic [31:0] ed);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.exp_resp = er; v.exp_rdata = ed;
    tbl.push_back(v);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d, md;
    logic [1:0]  r, mr;
    int          rise;

    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;

    // reset state of every output
    repeat (3) @(negedge clk);
    check("reset_handshakes", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
    check("reset_resp", {28'd0, bresp, rresp}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;

    // register map vectors, counter disabled throughout
    add_vec(0, 6'h0C, 0, 0, OKAY, CNT_RST);
    add_vec(0, 6'h00, 0, 0, OKAY, 32'h0);
    add_vec(0, 6'h04, 0, 0, OKAY, 32'h0);
    add_vec(1, 6'h08, 32'hAABBCCDD, 4'b0010, OKAY, 0);
    add_vec(0, 6'h08, 0, 0, OKAY, 32'h0000CC00);
    add_vec(1, 6'h08, 32'h12345678, 4'b1111, OKAY, 0);
    add_vec(1, 6'h08, 32'hFFFFFFFF, 4'b1001, OKAY, 0);
    add_vec(0, 6'h08, 0, 0, OKAY, 32'hFF3456FF);
    add_vec(0, 6'h10, 0, 0, SLVERR, 32'h0);
    add_vec(1, 6'h14, 32'hDEADBEEF, 4'b1111, SLVERR, 0);
    add_vec(0, 6'h08, 0, 0, OKAY, 32'hFF3456FF);
    add_vec(1, 6'h0C, 32'h00000055, 4'b1111, OKAY, 0);
    add_vec(0, 6'h0C, 0, 0, OKAY, CNT_RST);
    add_vec(1, 6'h00, 32'hFFFFFFF8, 4'b1111, OKAY, 0);
    add_vec(0, 6'h00, 0, 0, OKAY, 32'h0);
    add_vec(1, 6'h00, 32'h00000006, 4'b0001, OKAY, 0);
    add_vec(0, 6'h00, 0, 0, OKAY, 32'h6);
    add_vec(1, 6'h00, 32'h00000007, 4'b1110, OKAY, 0);
    add_vec(0, 6'h00, 0, 0, OKAY, 32'h6);
    add_vec(1, 6'h00, 32'h00000000, 4'b1111, OKAY, 0);
    add_vec(0, 6'h3C, 0, 0, SLVERR, 32'h0);
    add_vec(1, 6'h04, 32'hFFFFFFFF, 4'b1111, OKAY, 0);
    add_vec(0, 6'h04, 0, 0, OKAY, 32'h0);

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
        check($sformatf("tbl%0d_bresp", i), {30'd0, r}, {30'd0, tbl[i].exp_resp});
      end else begin
        axi_read(tbl[i].addr, d, r, md, mr);
        check($sformatf("tbl%0d_rresp", i), {30'd0, r}, {30'd0, tbl[i].exp_resp});
        check($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_rdata);
      end
    end

    // match interrupt: COUNT starts at 0 after the CTRL write edge, reaches
    // 0x10 sixteen cycles later, STATUS sets one edge after, irq one edge after that
    axi_write(6'h08, 32'h10, 4'hF, r);
    axi_write(6'h00, 32'h3, 4'hF, r);
    check("irq_low_at_enable", {31'd0, irq}, 32'd0);
    rise = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (irq) begin rise = i; break; end
    end
    check("irq_rise_cycle", rise, 32'd18);
    axi_write(6'h04, 32'h1, 4'hF, r);
    check("w1c_bresp", {30'd0, r}, {30'd0, OKAY});
    check("irq_one_cycle_after_w1c", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    axi_read(6'h0C, d, r, md, mr);
    check("count_past_0x11", {31'd0, (d > 32'h11)}, 32'd1);
    check("count_vs_model", d, md);
    axi_read(6'h04, d, r, md, mr);
    check("status_after_w1c", d, 32'd0);

    // auto-reload: COMPARE=5, COUNT runs 0..5 then reloads to 0
    pulse_reset();
    axi_write(6'h08, 32'h5, 4'hF, r);
    axi_write(6'h00, 32'h7, 4'hF, r);
    repeat (3) @(negedge clk);
    @(negedge clk); check("reload_seq_4", dut.count_q, 32'd4);
    @(negedge clk); check("reload_seq_5", dut.count_q, 32'd5);
    @(negedge clk); check("reload_seq_0", dut.count_q, 32'd0);
    @(negedge clk); check("reload_seq_1", dut.count_q, 32'd1);
    axi_read(6'h04, d, r, md, mr);
    check("reload_match_set", d, 32'd1);

    // stalled response blocks new writes; reset drops the response at once
    @(negedge clk);
    bready = 1'b0;
    awaddr = 6'h08; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    rise = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready) begin rise = 1; break; end
    end
    if (rise == 0) timeout_fail("stall_accept");
    m_wr_addr = 6'h08; m_wr_data = 32'h11111111; m_wr_strb = 4'hF; m_wr_go = 1'b1;
    @(negedge clk);
    m_wr_go = 1'b0;
    awaddr = 6'h00; wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_awready", i), {31'd0, awready}, 32'd0);
      check($sformatf("stall%0d_bvalid", i), {31'd0, bvalid}, 32'd1);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("reset_drops_bvalid", {31'd0, bvalid}, 32'd0);
    check("reset_awready_low", {31'd0, awready}, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    axi_read(6'h08, d, r, md, mr);
    check("compare_after_reset", d, 32'd0);

    // randomized traffic against the model
    for (int k = 0; k < 150; k++) begin
      logic [5:0]  a;
      logic [31:0] wd;
      logic [3:0]  ws;
      a = 6'($urandom_range(0, 6) * 4);
      if ($urandom_range(0, 1) == 1) begin
        wd = (a == 6'h08) ? 32'($urandom_range(0, 60)) : $urandom;
        ws = 4'($urandom_range(0, 15));
        axi_write(a, wd, ws, r);
        check($sformatf("rnd%0d_bresp", k), {30'd0, r}, (a < 6'h10) ? 32'd0 : 32'd2);
      end else begin
        axi_read(a, d, r, md, mr);
        check($sformatf("rnd%0d_rresp", k), {30'd0, r}, {30'd0, mr});
        check($sformatf("rnd%0d_rdata", k), d, md);
      end
      check($sformatf("rnd%0d_irq", k), {31'd0, irq}, {31'd0, m_irq});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
